// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: baud generation values and the default receive-queue depth.
package uart_rx_fifo_pkg;

    localparam int unsigned CLK_FREQ_HZ   = 50_000_000;
    localparam int unsigned BAUD_RATE     = 115_200;
    localparam int unsigned OVERSAMPLE    = 16;
    localparam int unsigned BAUD_DIV      = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned RX_FIFO_DEPTH = 16;

    // Encoding is {pop, push} so the helper below is a plain bit concatenation.
    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'b00,
        FIFO_PUSH     = 2'b01,
        FIFO_POP      = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte queue between a UART receiver and a bus reader: first-word fall-through,
// sticky overflow flag, flush, and a level-threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = RX_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    input  logic                     rd_req_i,
    output logic [7:0]               rd_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic                     irq_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i,
    input  logic                     flush_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [7:0]    mem0_q;
    logic [7:0]    mem_hi_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, push, pop, wr_en;
    fifo_op_e      op;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        pop      = rd_req_i && !empty;
        push     = rx_valid_i && (!full || pop);
        op       = fifo_op(push, pop);
        wr_en    = push && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (op)
                FIFO_PUSH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    level_d  = level_q + 1'b1;
                end
                FIFO_POP: begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    level_d  = level_q - 1'b1;
                end
                FIFO_PUSH_POP: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
        // Set beats clear; a byte discarded by flush is not an overflow.
        ovf_d = ovf_q;
        if (rx_valid_i && !push && !flush_i) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Only entry 0 is reset so rd_data_o reads 8'h00 after reset; the rest stays RAM-inferable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem0_q <= '0;
        end else if (wr_en && (wr_ptr_q == '0)) begin
            mem0_q <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && (wr_ptr_q != '0)) begin
            mem_hi_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign rd_data_o  = (rd_ptr_q == '0) ? mem0_q : mem_hi_q[rd_ptr_q];
    assign rd_valid_o = !empty;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign irq_o      = (thresh_i != '0) && (level_q >= thresh_i);

endmodule
